// File: rtl/knn_classifier_if.sv
// Query/result bundle for the k-NN classifier: one query in, five neighbour
// labels plus the majority-vote class out.
interface knn_classifier_if;
  logic [63:0] test_vector;
  logic [3:0]  c1;
  logic [3:0]  c2;
  logic [3:0]  c3;
  logic [3:0]  c4;
  logic [3:0]  c5;
  logic [3:0]  final_class;

  modport master (
    output test_vector,
    input  c1, c2, c3, c4, c5, final_class
  );

  modport slave (
    input  test_vector,
    output c1, c2, c3, c4, c5, final_class
  );
endinterface

// File: rtl/knn_classifier.sv
// Free-running k=5 nearest-neighbour classifier over a fixed 12-entry ROM.
// Each 18-cycle pass latches the query, streams the ROM through a 5-stage
// distance pipeline into a sorted top-5 list, then votes and registers results.
module knn_classifier (
  input logic             clk,
  input logic             rst,
  knn_classifier_if.slave bus
);

  localparam int unsigned K      = 5;
  localparam int unsigned NTrain = 12;
  localparam int unsigned NDrain = 4;
  localparam logic [33:0] DistMax = 34'h3_FFFF_FFFF;

  typedef enum logic [1:0] {StLoad, StIssue, StDrain, StVote} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [63:0] query_q;

  logic [63:0] rom_feat;
  logic [3:0]  rom_cls;

  logic        s1_valid_q;
  logic [63:0] s1_feat_q;
  logic [3:0]  s1_cls_q;
  logic        s2_valid_q;
  logic [15:0] s2_diff_q [4];
  logic [3:0]  s2_cls_q;
  logic        s3_valid_q;
  logic [31:0] s3_sq_q [4];
  logic [3:0]  s3_cls_q;
  logic        s4_valid_q;
  logic [33:0] s4_dist_q;
  logic [3:0]  s4_cls_q;

  logic [33:0] top_dist_q [K];
  logic [3:0]  top_cls_q  [K];
  logic [33:0] ins_dist   [K];
  logic [3:0]  ins_cls    [K];
  logic [K-1:0] lt;

  logic [2:0]  vote_cnt [K];
  logic [2:0]  best_cnt;
  logic [3:0]  vote_cls;

  logic [3:0]  c_q [K];
  logic [3:0]  final_q;

  // Training ROM, addressed by the issue counter.
  always_comb begin
    rom_feat = '0;
    rom_cls  = '0;
    unique case (cnt_q)
      4'd0:  begin rom_feat = {16'd51, 16'd35, 16'd14, 16'd2};  rom_cls = 4'd0; end
      4'd1:  begin rom_feat = {16'd49, 16'd30, 16'd14, 16'd2};  rom_cls = 4'd0; end
      4'd2:  begin rom_feat = {16'd47, 16'd32, 16'd13, 16'd2};  rom_cls = 4'd0; end
      4'd3:  begin rom_feat = {16'd50, 16'd36, 16'd14, 16'd2};  rom_cls = 4'd0; end
      4'd4:  begin rom_feat = {16'd70, 16'd32, 16'd47, 16'd14}; rom_cls = 4'd1; end
      4'd5:  begin rom_feat = {16'd64, 16'd32, 16'd45, 16'd15}; rom_cls = 4'd1; end
      4'd6:  begin rom_feat = {16'd55, 16'd23, 16'd40, 16'd13}; rom_cls = 4'd1; end
      4'd7:  begin rom_feat = {16'd65, 16'd28, 16'd46, 16'd15}; rom_cls = 4'd1; end
      4'd8:  begin rom_feat = {16'd63, 16'd33, 16'd60, 16'd25}; rom_cls = 4'd2; end
      4'd9:  begin rom_feat = {16'd58, 16'd27, 16'd51, 16'd19}; rom_cls = 4'd2; end
      4'd10: begin rom_feat = {16'd71, 16'd30, 16'd59, 16'd21}; rom_cls = 4'd2; end
      4'd11: begin rom_feat = {16'd65, 16'd30, 16'd58, 16'd22}; rom_cls = 4'd2; end
      default: begin rom_feat = '0; rom_cls = '0; end
    endcase
  end

  // Sorted insertion: the list is ordered, so lt is a thermometer code and the
  // first set bit is where the new entry lands. Ties keep the older entry ahead.
  always_comb begin
    for (int j = 0; j < K; j++) begin
      lt[j] = s4_dist_q < top_dist_q[j];
    end
    ins_dist[0] = lt[0] ? s4_dist_q : top_dist_q[0];
    ins_cls[0]  = lt[0] ? s4_cls_q  : top_cls_q[0];
    for (int j = 1; j < K; j++) begin
      if (!lt[j]) begin
        ins_dist[j] = top_dist_q[j];
        ins_cls[j]  = top_cls_q[j];
      end else if (!lt[j-1]) begin
        ins_dist[j] = s4_dist_q;
        ins_cls[j]  = s4_cls_q;
      end else begin
        ins_dist[j] = top_dist_q[j-1];
        ins_cls[j]  = top_cls_q[j-1];
      end
    end
  end

  // Majority vote; scanning from the nearest slot with a strict compare makes
  // the earliest-appearing class win a tied count.
  always_comb begin
    best_cnt = '0;
    vote_cls = '0;
    for (int j = 0; j < K; j++) begin
      vote_cnt[j] = '0;
      for (int k = 0; k < K; k++) begin
        vote_cnt[j] = vote_cnt[j] + 3'(top_cls_q[k] == top_cls_q[j]);
      end
      if (vote_cnt[j] > best_cnt) begin
        best_cnt = vote_cnt[j];
        vote_cls = top_cls_q[j];
      end
    end
  end

  // Distance pipeline S1..S4; valid tracks which stages hold a real ROM entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_feat_q  <= '0;
      s1_cls_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_cls_q   <= '0;
      s3_valid_q <= 1'b0;
      s3_cls_q   <= '0;
      s4_valid_q <= 1'b0;
      s4_dist_q  <= '0;
      s4_cls_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        s2_diff_q[i] <= '0;
        s3_sq_q[i]   <= '0;
      end
    end else begin
      s1_valid_q <= (state_q == StIssue);
      s1_feat_q  <= rom_feat;
      s1_cls_q   <= rom_cls;
      s2_valid_q <= s1_valid_q;
      s2_cls_q   <= s1_cls_q;
      for (int i = 0; i < 4; i++) begin
        if (query_q[63-16*i -: 16] >= s1_feat_q[63-16*i -: 16]) begin
          s2_diff_q[i] <= query_q[63-16*i -: 16] - s1_feat_q[63-16*i -: 16];
        end else begin
          s2_diff_q[i] <= s1_feat_q[63-16*i -: 16] - query_q[63-16*i -: 16];
        end
        s3_sq_q[i] <= 32'(s2_diff_q[i]) * 32'(s2_diff_q[i]);
      end
      s3_valid_q <= s2_valid_q;
      s3_cls_q   <= s2_cls_q;
      s4_valid_q <= s3_valid_q;
      s4_cls_q   <= s3_cls_q;
      s4_dist_q  <= 34'(s3_sq_q[0]) + 34'(s3_sq_q[1]) + 34'(s3_sq_q[2]) + 34'(s3_sq_q[3]);
    end
  end

  // Pass controller: owns the query, the top-5 list and the registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StLoad;
      cnt_q   <= '0;
      query_q <= '0;
      final_q <= '0;
      for (int j = 0; j < K; j++) begin
        top_dist_q[j] <= '0;
        top_cls_q[j]  <= '0;
        c_q[j]        <= '0;
      end
    end else begin
      if (s4_valid_q) begin
        for (int j = 0; j < K; j++) begin
          top_dist_q[j] <= ins_dist[j];
          top_cls_q[j]  <= ins_cls[j];
        end
      end
      unique case (state_q)
        StLoad: begin
          query_q <= bus.test_vector;
          cnt_q   <= '0;
          for (int j = 0; j < K; j++) begin
            top_dist_q[j] <= DistMax;
            top_cls_q[j]  <= '0;
          end
          state_q <= StIssue;
        end
        StIssue: begin
          if (cnt_q == 4'(NTrain - 1)) begin
            cnt_q   <= '0;
            state_q <= StDrain;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StDrain: begin
          if (cnt_q == 4'(NDrain - 1)) begin
            cnt_q   <= '0;
            state_q <= StVote;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StVote: begin
          for (int j = 0; j < K; j++) begin
            c_q[j] <= top_cls_q[j];
          end
          final_q <= vote_cls;
          state_q <= StLoad;
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign bus.c1          = c_q[0];
  assign bus.c2          = c_q[1];
  assign bus.c3          = c_q[2];
  assign bus.c4          = c_q[3];
  assign bus.c5          = c_q[4];
  assign bus.final_class = final_q;

endmodule

// File: tb/tb_knn_classifier.sv
// Self-checking bench for knn_classifier: directed queries with known answers,
// reset/latency and query-stability sequences, then random queries scored
// against a brute-force nearest-neighbour model.
module tb_knn_classifier;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  knn_classifier_if bus ();

  knn_classifier dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int rom_f [12][4] = '{
    '{51, 35, 14, 2},  '{49, 30, 14, 2},  '{47, 32, 13, 2},  '{50, 36, 14, 2},
    '{70, 32, 47, 14}, '{64, 32, 45, 15}, '{55, 23, 40, 13}, '{65, 28, 46, 15},
    '{63, 33, 60, 25}, '{58, 27, 51, 19}, '{71, 30, 59, 21}, '{65, 30, 58, 22}
  };
  int rom_c [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
  string fld [6] = '{"c1", "c2", "c3", "c4", "c5", "final_class"};

  function automatic logic [63:0] mkq(int a, int b, int c, int d);
    return {16'(a), 16'(b), 16'(c), 16'(d)};
  endfunction

  // Brute force: all 12 distances, pick the 5 smallest (lower index on ties),
  // then the most frequent class, earliest neighbour breaking count ties.
  function automatic logic [23:0] model(logic [63:0] q);
    int      qf [4];
    longint  d [12];
    bit      used [12];
    int      cls [5];
    int      cnt [3];
    int      best;
    int      m;
    int      fin;
    longint  diff;
    for (int f = 0; f < 4; f++) qf[f] = int'(q[63-16*f -: 16]);
    for (int t = 0; t < 12; t++) begin
      d[t] = 0;
      used[t] = 1'b0;
      for (int f = 0; f < 4; f++) begin
        diff = longint'(qf[f]) - longint'(rom_f[t][f]);
        d[t] += diff * diff;
      end
    end
    for (int p = 0; p < 5; p++) begin
      best = -1;
      for (int t = 0; t < 12; t++) begin
        if (!used[t] && (best < 0 || d[t] < d[best])) best = t;
      end
      used[best] = 1'b1;
      cls[p] = rom_c[best];
    end
    for (int c = 0; c < 3; c++) cnt[c] = 0;
    for (int p = 0; p < 5; p++) cnt[cls[p]]++;
    m = 0;
    for (int c = 0; c < 3; c++) if (cnt[c] > m) m = cnt[c];
    fin = -1;
    for (int p = 0; p < 5; p++) if (fin < 0 && cnt[cls[p]] == m) fin = cls[p];
    return {4'(cls[0]), 4'(cls[1]), 4'(cls[2]), 4'(cls[3]), 4'(cls[4]), 4'(fin)};
  endfunction

  task automatic check_out(string tag, logic [23:0] exp);
    logic [23:0] obs;
    obs = {bus.c1, bus.c2, bus.c3, bus.c4, bus.c5, bus.final_class};
    for (int k = 0; k < 6; k++) begin
      checks++;
      assert (obs[23-4*k -: 4] === exp[23-4*k -: 4]) else begin
        failures++;
        $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld[k],
               obs[23-4*k -: 4], exp[23-4*k -: 4]);
      end
    end
  endtask

  localparam logic [23:0] Zero = 24'h0;
  localparam logic [23:0] Exp1 = {4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
  localparam logic [23:0] Exp2 = {4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd1};
  localparam logic [23:0] Exp3 = {4'd2, 4'd2, 4'd2, 4'd2, 4'd1, 4'd2};
  localparam logic [23:0] Exp4 = {4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd1};

  initial begin
    logic [63:0] q;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.test_vector = mkq(52, 36, 15, 3);

    // Held in reset: everything zero.
    repeat (3) @(posedge clk);
    #1 check_out("reset_hold", Zero);

    // Release; edge 0 is the next rising edge, results land on edge 17.
    @(negedge clk);
    rst = 1'b0;
    repeat (17) @(posedge clk);
    #1 check_out("pre_vote", Zero);
    @(posedge clk);
    #1 check_out("first_vote_q1", Exp1);

    // Change query during ISSUE of the pass that loaded at edge 18.
    repeat (3) @(posedge clk);
    #1 bus.test_vector = mkq(69, 33, 46, 15);
    for (int e = 21; e <= 52; e++) begin
      @(posedge clk);
      #1 check_out("hold_old_q1", Exp1);
    end
    @(posedge clk);
    #1 check_out("new_q2", Exp2);

    bus.test_vector = mkq(64, 34, 59, 24);
    repeat (40) @(posedge clk);
    #1 check_out("q3", Exp3);

    bus.test_vector = mkq(60, 29, 31, 8);
    repeat (40) @(posedge clk);
    #1 check_out("q4_boundary", Exp4);

    // Mid-pass reset clears outputs without waiting for a clock edge.
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_out("async_reset", Zero);
    @(negedge clk);
    rst = 1'b0;
    repeat (17) @(posedge clk);
    #1 check_out("post_reset_pre_vote", Zero);
    @(posedge clk);
    #1 check_out("post_reset_q4", Exp4);

    // Random queries: mostly near the training data, some full-range.
    for (int n = 0; n < 24; n++) begin
      if (n % 4 == 3) begin
        q = {$urandom, $urandom};
      end else begin
        q = mkq(int'($urandom_range(40, 75)), int'($urandom_range(20, 40)),
                int'($urandom_range(10, 62)), int'($urandom_range(1, 26)));
      end
      bus.test_vector = q;
      repeat (36) @(posedge clk);
      #1 check_out("random", model(q));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/knn_classifier.md
# knn_classifier

Fixed-function k-nearest-neighbour classifier (k = 5) for 4-feature Iris-style samples, used as the classification accelerator in the KNN datapath. It compares one 64-bit query vector against a built-in 12-entry labelled training ROM through a 5-stage pipeline. It keeps the five nearest entries sorted by squared Euclidean distance and outputs their class labels plus a majority-vote class. It runs continuously, re-classifying the current query every pass.

## Interface
- Parameters: none; K = 5, N_TRAIN = 12 and ROM contents are fixed.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, asynchronous and active-high; clears all state.
- test_vector  input  64  query {f0[63:48], f1[47:32], f2[31:16], f3[15:0]}, unsigned 16-bit features (feature ×10).
- c1..c5  output  4 each  class labels of the 1st..5th nearest training entries; c1 = nearest.
- final_class  output  4  majority-vote class (0 Setosa, 1 Versicolor, 2 Virginica).

## Operation
- Training ROM (index: f0,f1,f2,f3 → class):
  - 0: 51,35,14,2→0; 1: 49,30,14,2→0; 2: 47,32,13,2→0; 3: 50,36,14,2→0
  - 4: 70,32,47,14→1; 5: 64,32,45,15→1; 6: 55,23,40,13→1; 7: 65,28,46,15→1
  - 8: 63,33,60,25→2; 9: 58,27,51,19→2; 10: 71,30,59,21→2; 11: 65,30,58,22→2
- Controller states: LOAD → ISSUE (12 cycles) → DRAIN (4 cycles) → VOTE (1 cycle) → LOAD. Runs forever with no start or valid handshake.
- LOAD:
  - Latch test_vector into an internal query register; the query is constant for the whole pass.
  - Set all five top-5 slots to distance 0x3_FFFF_FFFF (max), class 0.
- Pipeline stages:
  - S1: ROM read at the issue index.
  - S2: |q_i − t_i| per feature, 16-bit unsigned.
  - S3: square each difference, 32-bit.
  - S4: sum of the four squares, 34-bit, no overflow possible.
  - S5: sorted insertion into the top-5 list.
- Insertion rules:
  - Insert when the new distance is strictly less than a slot's distance. Shift worse entries down and drop slot 5.
  - On an equal distance the existing (lower-index) entry ranks first.
- VOTE:
  - Count the classes in the 5 slots; final_class = class with the highest count.
  - On a tied count, pick the tied class that appears earliest in c1..c5.
  - Register c1..c5 and final_class together.
- Outputs hold between VOTE cycles. Classes outside 0..2 never occur; upper bits are 0.

## Timing
- Cycle 0 is the first rising edge after rst deasserts; LOAD executes on it.
- Index i issues to S1 at cycle 1+i. Its S5 insert happens at cycle 5+i; the last insert is at cycle 16.
- VOTE is at cycle 17, so outputs update on that edge; the next LOAD is at cycle 18.
- Pass period is 18 cycles.
- A query change is reflected at the VOTE of the first pass whose LOAD sees it: at most 35 cycles later.
- Reset values: c1..c5 = 0, final_class = 0, pipeline and top-5 cleared, state = LOAD.
- Reset mid-pass: all state clears immediately and the pass restarts from LOAD.
- test_vector changes mid-pass have no effect until the next LOAD.

## Test plan
- Query {52,36,15,3}: after ≥40 cycles → c1..c5 = 0,0,0,0,1 and final_class = 0. Sorted distances are 4,6,46,47,903.
- Query {69,33,46,15} → c1..c5 = 1,1,1,2,2 and final_class = 1. Sorted distances are 4,27,41,198,218.
- Query {64,34,59,24} → c1..c5 = 2,2,2,2,1 and final_class = 2.
- Query {60,29,31,8} (boundary) → c1..c5 = 1,1,1,1,0 and final_class = 1. Fifth entry is index 0 at distance 442.
- Reset/latency:
  - Hold rst high → all outputs 0.
  - Release rst → outputs remain 0 until the cycle-17 edge, then take the query result.
  - Assert rst mid-pass → outputs return to 0 asynchronously.
- Query stability:
  - Change the query during ISSUE → the current pass completes with the old query.
  - The new result appears by the second following VOTE.
  - Outputs never show a mixed result.
